lsu_if: RTL and testbench
=========================

Name: lsu_if

Overview:
- Front-end sequencer between the RV32I execute/memory stage and the LSU; converts one load/store request into LSU bus cycles.
- Store path: byte-lane strobes, lane-shifted store data, single-cycle write pulse.
- Load path: issues a word read, waits for LSU data-valid, extracts and extends the addressed byte/halfword/word, returns it with a done pulse.
- Detects misaligned accesses without touching the bus; optionally times out unanswered loads.

Parameters:
- TIMEOUT_CYC, 16: max WAIT cycles before a load is aborted (used only with LSU_IF_TIMEOUT_EN).
- CNT_W, 5: timeout counter width; must hold TIMEOUT_CYC.

Ports:
- i_clk  in  1  system clock
- i_rst  in  1  asynchronous active-low reset
- i_req  in  1  request valid from pipeline
- o_ready  out  1  high only in IDLE; request accepted when i_req & o_ready
- i_wren  in  1  1=store, 0=load
- i_funct3  in  3  RV32I width/sign: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores use 000/001/010
- i_addr  in  32  byte address
- i_wdata  in  32  store data, right-aligned
- o_done  out  1  one-cycle completion pulse
- o_rdata  out  32  load result, valid with o_done, held until next o_done
- o_err  out  1  valid with o_done: misaligned or timeout
- o_lsu_addr  out  32  to LSU, always {addr[31:2],2'b00}
- o_st_data  out  32  to LSU, lane-shifted store data
- o_st_strb  out  4  to LSU byte strobes
- o_lsu_wren  out  1  to LSU write enable
- i_ld_data  in  32  from LSU load data
- i_data_vld  in  1  from LSU, registered one cycle after address

Behaviour:
- Reset values: o_ready=1, o_done=0, o_err=0, o_rdata=0, o_lsu_addr=0, o_st_data=0, o_st_strb=0, o_lsu_wren=0. State=IDLE.
- Accept: in IDLE with i_req=1, latch i_wren, i_funct3, i_addr, i_wdata. Request inputs are ignored outside IDLE.
- Misalignment: halfword with addr[0]=1, or word with addr[1:0]!=0.
  - Next state ERR; o_done=o_err=1 for one cycle; o_rdata unchanged; no LSU access (o_lsu_wren stays 0).
- Strobes: byte = 4'b0001<<addr[1:0]; half = 4'b0011<<addr[1]*2; word = 4'b1111.
- Store data: byte is wdata[7:0] replicated to all lanes; half is wdata[15:0] replicated; word unchanged.
- Reserved funct3 values (011, 110, 111) are treated as a misaligned error.
- FSM states: IDLE, STORE, LD_ADDR, LD_WAIT, RESP, ERR.
- Store:
  - Cycle after accept: STORE, with o_lsu_wren=1, strobes and data valid, for exactly one cycle.
  - Next cycle: RESP, o_done=1, o_err=0, o_rdata unchanged.
  - Latency from accept to done: 2 cycles.
- Load, LD_ADDR:
  - One cycle with address driven and o_lsu_wren=0.
  - i_data_vld is ignored here, because it reflects the previously held address.
- Load, LD_WAIT:
  - First cycle with i_data_vld=1 captures i_ld_data, goes to RESP, and drives o_done=1 with o_rdata valid.
  - Minimum latency from accept to done: 3 cycles.
- Load extract:
  - Byte lane = addr[1:0]; halfword = addr[1] ? [31:16] : [15:0].
  - LB/LH sign-extend; LBU/LHU zero-extend.
- RESP and ERR each last one cycle, then return to IDLE. o_ready=0 in every state except IDLE, so back-to-back requests cost one extra cycle.
- o_lsu_addr holds its last value outside active states; o_lsu_wren=0 and o_st_strb=0 outside STORE.
- Reset asserted mid-operation aborts the access immediately; no o_done is produced.

Optional Feature:
- LSU_IF_TIMEOUT_EN defined:
  - Counter clears on entering LD_WAIT and increments each WAIT cycle.
  - When it reaches TIMEOUT_CYC, go to RESP with o_err=1 and o_rdata=0.
  - If i_data_vld and timeout occur in the same cycle, data wins.
- Not defined: no counter; LD_WAIT waits indefinitely.

Decomposition:
- Shared package lsu_pkg:
  - funct3 enum (F3_B, F3_H, F3_W, F3_BU, F3_HU).
  - lsu_if state enum.
  - MMIO/data base-address constants shared with the LSU.
- Sub-module lsu_ld_align: combinational lane extract and sign/zero extend; inputs data, addr[1:0], funct3.

Test Plan:
- SB addr 0x2003, wdata 0xAB → STORE cycle with strb 4'b1000, st_data 0xABABABAB, o_lsu_addr 0x2000; done at accept+2, err=0.
- LH addr 0x2002; LSU returns 0x8001_1234 → o_rdata 0xFFFF8001, done at accept+3.
- LHU addr 0x2002, same data → 0x00008001. LBU addr 0x2001, data 0x0000C300 → 0x000000C3.
- LW addr 0x2006 → done+err at accept+1, o_lsu_wren never 1, o_rdata unchanged.
- Stale vld: i_data_vld held high across IDLE→LD_ADDR → value captured only in LD_WAIT.
- With LSU_IF_TIMEOUT_EN, TIMEOUT_CYC=4, vld never asserted → done, err=1, rdata=0 at accept+2+4. Reset mid-LD_WAIT → IDLE, no done.

Source files
------------

// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : lsu_pkg
//  Purpose  : Shared types and helpers for the load/store front-end and the
//             LSU: RV32I funct3 width codes, sequencer state encoding,
//             address-map constants and store-lane helper functions.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package lsu_pkg;

    // RV32I load/store width and sign selection
    typedef enum logic [2:0] {
        F3_B  = 3'b000,
        F3_H  = 3'b001,
        F3_W  = 3'b010,
        F3_BU = 3'b100,
        F3_HU = 3'b101
    } funct3_e;

    // Sequencer states
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_STORE   = 3'd1,
        S_LD_ADDR = 3'd2,
        S_LD_WAIT = 3'd3,
        S_RESP    = 3'd4,
        S_ERR     = 3'd5
    } state_e;

    // Address map shared with the LSU
    localparam logic [31:0] c_DATA_BASE = 32'h0000_2000;
    localparam logic [31:0] c_MMIO_BASE = 32'h1000_0000;

    // Reserved width codes are reported the same way as a misaligned access.
    function automatic logic f_misaligned(input logic [2:0] f3, input logic [1:0] lo);
        logic mis;
        case (f3)
            F3_B, F3_BU: mis = 1'b0;
            F3_H, F3_HU: mis = lo[0];
            F3_W:        mis = (lo != 2'b00);
            default:     mis = 1'b1;
        endcase
        return mis;
    endfunction

    // Byte-lane strobes for a store; only called for aligned accesses.
    function automatic logic [3:0] f_strb(input logic [2:0] f3, input logic [1:0] lo);
        logic [3:0] strb;
        case (f3[1:0])
            2'b00:   strb = 4'b0001 << lo;
            2'b01:   strb = 4'b0011 << {lo[1], 1'b0};
            default: strb = 4'b1111;
        endcase
        return strb;
    endfunction

    // Replicating the low byte/halfword puts it on every lane, so the strobe
    // alone selects the destination and no barrel shifter is needed.
    function automatic logic [31:0] f_st_data(input logic [2:0] f3, input logic [31:0] wd);
        logic [31:0] d;
        case (f3[1:0])
            2'b00:   d = {4{wd[7:0]}};
            2'b01:   d = {2{wd[15:0]}};
            default: d = wd;
        endcase
        return d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_if_if.sv
`default_nettype none
// ============================================================================
//  Module   : lsu_if_if
//  Purpose  : Bundle of the pipeline request/response signals and the LSU
//             bus signals around the lsu_if sequencer.
//  Modports : slave  - the sequencer (consumes i_*, drives o_*)
//             master - the environment (pipeline + LSU)
//  Revision : 1.0 - initial release
// ============================================================================
interface lsu_if_if;
    // pipeline side
    logic        i_req;
    logic        o_ready;
    logic        i_wren;
    logic [2:0]  i_funct3;
    logic [31:0] i_addr;
    logic [31:0] i_wdata;
    logic        o_done;
    logic [31:0] o_rdata;
    logic        o_err;
    // LSU side
    logic [31:0] o_lsu_addr;
    logic [31:0] o_st_data;
    logic [3:0]  o_st_strb;
    logic        o_lsu_wren;
    logic [31:0] i_ld_data;
    logic        i_data_vld;

    modport slave (
        input  i_req, i_wren, i_funct3, i_addr, i_wdata, i_ld_data, i_data_vld,
        output o_ready, o_done, o_rdata, o_err,
               o_lsu_addr, o_st_data, o_st_strb, o_lsu_wren
    );

    modport master (
        output i_req, i_wren, i_funct3, i_addr, i_wdata, i_ld_data, i_data_vld,
        input  o_ready, o_done, o_rdata, o_err,
               o_lsu_addr, o_st_data, o_st_strb, o_lsu_wren
    );
endinterface
`default_nettype wire

// File: rtl/lsu_ld_align.sv
`default_nettype none
// ============================================================================
//  Module   : lsu_ld_align
//  Purpose  : Combinational load-data aligner: picks the addressed byte or
//             halfword out of a 32-bit LSU word and sign/zero extends it.
//  Ports    : data    in  32  raw word from the LSU
//             addr_lo in  2   byte offset within the word
//             funct3  in  3   RV32I width/sign code
//             result  out 32  right-aligned, extended load value
//  Revision : 1.0 - initial release
// ============================================================================
module lsu_ld_align (
    input  logic [31:0] data,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  funct3,
    output logic [31:0] result
);
    import lsu_pkg::*;

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = data[{addr_lo, 3'b000} +: 8];
        w_half = addr_lo[1] ? data[31:16] : data[15:0];
        result = data;
        case (funct3)
            F3_B:    result = {{24{w_byte[7]}}, w_byte};
            F3_BU:   result = {24'd0, w_byte};
            F3_H:    result = {{16{w_half[15]}}, w_half};
            F3_HU:   result = {16'd0, w_half};
            default: result = data;
        endcase
    end
endmodule
`default_nettype wire

// File: rtl/lsu_if.sv
`default_nettype none
// ============================================================================
//  Module   : lsu_if
//  Purpose  : Sequencer between the RV32I execute/memory stage and the LSU.
//             Turns one load/store request into LSU bus cycles, aligns load
//             data, flags misaligned/reserved accesses without touching the
//             bus. Optional load timeout under `LSU_IF_TIMEOUT_EN`.
//  Params   : TIMEOUT_CYC - WAIT cycles before an unanswered load aborts
//             CNT_W       - timeout counter width
//  Ports    : i_clk  in  clock
//             i_rst  in  asynchronous active-low reset
//             bus        lsu_if_if.slave (request, response and LSU signals)
//  Revision : 1.0 - initial release
// ============================================================================
module lsu_if #(
    parameter int TIMEOUT_CYC = 16,
    parameter int CNT_W       = 5
) (
    input  logic     i_clk,
    input  logic     i_rst,
    lsu_if_if.slave  bus
);
    import lsu_pkg::*;

    state_e      r_state;
    state_e      w_state_nxt;
    logic [2:0]  r_f3;
    logic [1:0]  r_addr_lo;
    logic [31:0] r_lsu_addr;
    logic [31:0] r_st_data;
    logic [31:0] r_rdata;
    logic [3:0]  r_strb;
    logic        r_err;

    logic        w_accept;
    logic        w_mis;
    logic        w_capture;
    logic        w_timeout;
    logic        w_ready;
    logic        w_done;
    logic        w_wr_en;
    logic [31:0] w_ld_ext;

    assign w_accept  = (r_state == S_IDLE) && bus.i_req;
    assign w_mis     = f_misaligned(bus.i_funct3, bus.i_addr[1:0]);
    // LD_ADDR is skipped on purpose: a valid seen there belongs to the
    // previously presented address.
    assign w_capture = (r_state == S_LD_WAIT) && bus.i_data_vld;

    // A counter too narrow to reach TIMEOUT_CYC-1 would never fire.
    generate
        if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > (1 << CNT_W)) begin : g_bad_timeout_cfg
        end
    endgenerate

`ifdef LSU_IF_TIMEOUT_EN
    logic [CNT_W-1:0] r_cnt;

    // Data arriving on the last allowed cycle takes priority over the abort.
    assign w_timeout = (r_state == S_LD_WAIT) && !bus.i_data_vld &&
                       (r_cnt == CNT_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst)
            r_cnt <= '0;
        else if (r_state != S_LD_WAIT)
            r_cnt <= '0;
        else
            r_cnt <= r_cnt + 1'b1;
    end
`else
    assign w_timeout = 1'b0;
`endif

    // State register
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    // Next state and state-decoded outputs
    always_comb begin
        w_state_nxt = r_state;
        w_ready     = 1'b0;
        w_done      = 1'b0;
        w_wr_en     = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_ready = 1'b1;
                if (bus.i_req)
                    w_state_nxt = w_mis ? S_ERR : (bus.i_wren ? S_STORE : S_LD_ADDR);
            end
            S_STORE: begin
                w_wr_en     = 1'b1;
                w_state_nxt = S_RESP;
            end
            S_LD_ADDR: w_state_nxt = S_LD_WAIT;
            S_LD_WAIT: begin
                if (w_capture || w_timeout)
                    w_state_nxt = S_RESP;
            end
            S_RESP, S_ERR: begin
                w_done      = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Request latch and response datapath
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_f3       <= 3'd0;
            r_addr_lo  <= 2'd0;
            r_lsu_addr <= 32'd0;
            r_st_data  <= 32'd0;
            r_strb     <= 4'd0;
            r_rdata    <= 32'd0;
            r_err      <= 1'b0;
        end else begin
            if (w_accept) begin
                r_f3      <= bus.i_funct3;
                r_addr_lo <= bus.i_addr[1:0];
                r_err     <= w_mis;
                // A rejected access leaves the LSU-facing registers untouched.
                if (!w_mis) begin
                    r_lsu_addr <= {bus.i_addr[31:2], 2'b00};
                    r_strb     <= f_strb(bus.i_funct3, bus.i_addr[1:0]);
                    if (bus.i_wren)
                        r_st_data <= f_st_data(bus.i_funct3, bus.i_wdata);
                end
            end
            if (w_capture) begin
                r_rdata <= w_ld_ext;
                r_err   <= 1'b0;
            end else if (w_timeout) begin
                r_rdata <= 32'd0;
                r_err   <= 1'b1;
            end
        end
    end

    lsu_ld_align u_ld_align (
        .data    (bus.i_ld_data),
        .addr_lo (r_addr_lo),
        .funct3  (r_f3),
        .result  (w_ld_ext)
    );

    assign bus.o_ready    = w_ready;
    assign bus.o_done     = w_done;
    assign bus.o_err      = w_done & r_err;
    assign bus.o_rdata    = r_rdata;
    assign bus.o_lsu_addr = r_lsu_addr;
    assign bus.o_st_data  = r_st_data;
    assign bus.o_st_strb  = w_wr_en ? r_strb : 4'd0;
    assign bus.o_lsu_wren = w_wr_en;

endmodule
`default_nettype wire

// File: tb/tb_lsu_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_lsu_if
//  Purpose  : Self-checking bench for lsu_if: directed and randomized
//             loads/stores checked against a behavioural memory-access model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_lsu_if;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    int          n_pass = 0;
    int          n_total = 0;
    int          cyc = 0;
    int          done_cyc = 0;
    logic [31:0] last_rdata = 32'd0;

    lsu_if_if bus();

    lsu_if #(.TIMEOUT_CYC(4), .CNT_W(5)) u_dut (
        .i_clk (clk),
        .i_rst (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- behavioural reference model ----------------
    function automatic int m_size(input logic [2:0] f3);
        case (f3)
            3'd0, 3'd4: return 1;
            3'd1, 3'd5: return 2;
            3'd2:       return 4;
            default:    return 0;
        endcase
    endfunction

    function automatic bit m_mis(input logic [2:0] f3, input logic [31:0] a);
        int sz = m_size(f3);
        if (sz == 0) return 1'b1;
        return (int'(a[1:0]) % sz) != 0;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] data);
        int     sz = m_size(f3);
        int     lo = int'(a[1:0]);
        longint v;
        longint span;
        v = longint'(data >> (8 * lo));
        if (sz < 4) begin
            span = longint'(1) << (8 * sz);
            v = v % span;
            if (f3 < 3'd4 && v >= span / 2) v = v - span;
        end
        return 32'(v);
    endfunction

    function automatic logic [3:0] m_strb(input logic [2:0] f3, input logic [31:0] a);
        int         sz = m_size(f3);
        logic [3:0] s;
        s = 4'((1 << sz) - 1);
        return s << a[1:0];
    endfunction

    function automatic logic [31:0] m_stdata(input logic [2:0] f3, input logic [31:0] wd);
        int          sz = m_size(f3);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % sz) +: 8];
        return r;
    endfunction

    // ---------------- transaction drivers ----------------
    task automatic issue(input logic wr, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input logic stale);
        int n = 0;
        @(negedge clk);
        bus.i_req = 1'b1; bus.i_wren = wr; bus.i_funct3 = f3;
        bus.i_addr = a; bus.i_wdata = wd;
        bus.i_data_vld = stale; bus.i_ld_data = $urandom;
        while (bus.o_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        n_total++;
        if (bus.o_ready !== 1'b1) $display("FAIL accept: o_ready=%b required 1", bus.o_ready);
        else n_pass++;
        @(posedge clk); #1;
        // scramble request fields: they must be ignored from here on
        bus.i_req = 1'b0; bus.i_wren = 1'($urandom); bus.i_funct3 = 3'($urandom);
        bus.i_addr = $urandom; bus.i_wdata = $urandom;
    endtask

    task automatic run_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
        logic [3:0]  e_strb = m_strb(f3, a);
        logic [31:0] e_data = m_stdata(f3, wd);
        logic [31:0] e_addr = a & 32'hFFFF_FFFC;
        issue(1'b1, f3, a, wd, 1'b0);
        n_total++;
        if (bus.o_lsu_wren !== 1'b1 || bus.o_st_strb !== e_strb || bus.o_st_data !== e_data ||
            bus.o_lsu_addr !== e_addr || bus.o_done !== 1'b0)
            $display("FAIL store_cycle a=%h: wren=%b strb=%b data=%h addr=%h done=%b required wren=1 strb=%b data=%h addr=%h done=0",
                     a, bus.o_lsu_wren, bus.o_st_strb, bus.o_st_data, bus.o_lsu_addr, bus.o_done,
                     e_strb, e_data, e_addr);
        else n_pass++;
        @(posedge clk); #1;
        n_total++;
        if (bus.o_done !== 1'b1 || bus.o_err !== 1'b0 || bus.o_rdata !== last_rdata ||
            bus.o_lsu_wren !== 1'b0 || bus.o_st_strb !== 4'd0)
            $display("FAIL store_done a=%h: done=%b err=%b rdata=%h wren=%b strb=%b required done=1 err=0 rdata=%h wren=0 strb=0",
                     a, bus.o_done, bus.o_err, bus.o_rdata, bus.o_lsu_wren, bus.o_st_strb, last_rdata);
        else n_pass++;
        done_cyc = cyc;
    endtask

    // d = LD_WAIT cycle (1-based) in which the LSU answers
    task automatic run_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] data,
                            input int d, input logic stale);
        logic [31:0] e_rd = m_load(f3, a, data);
        logic [31:0] e_addr = a & 32'hFFFF_FFFC;
        issue(1'b0, f3, a, $urandom, stale);
        for (int c = 1; c <= d + 2; c++) begin
            bus.i_data_vld = (c == 1) ? stale : (c == d + 1);
            bus.i_ld_data  = (c == d + 1) ? data : $urandom;
            n_total++;
            if (c == 1) begin
                if (bus.o_lsu_addr !== e_addr || bus.o_lsu_wren !== 1'b0 || bus.o_done !== 1'b0)
                    $display("FAIL load_addr a=%h: addr=%h wren=%b done=%b required addr=%h wren=0 done=0",
                             a, bus.o_lsu_addr, bus.o_lsu_wren, bus.o_done, e_addr);
                else n_pass++;
            end else if (c < d + 2) begin
                if (bus.o_done !== 1'b0 || bus.o_ready !== 1'b0)
                    $display("FAIL load_wait a=%h cycle %0d: done=%b ready=%b required 0 0",
                             a, c, bus.o_done, bus.o_ready);
                else n_pass++;
            end else begin
                if (bus.o_done !== 1'b1 || bus.o_err !== 1'b0 || bus.o_rdata !== e_rd)
                    $display("FAIL load_done f3=%0d a=%h data=%h: done=%b err=%b rdata=%h required done=1 err=0 rdata=%h",
                             f3, a, data, bus.o_done, bus.o_err, bus.o_rdata, e_rd);
                else n_pass++;
            end
            if (c < d + 2) begin @(posedge clk); #1; end
        end
        bus.i_data_vld = 1'b0;
        last_rdata = e_rd;
        done_cyc = cyc;
    endtask

    task automatic run_mis(input logic wr, input logic [2:0] f3, input logic [31:0] a);
        issue(wr, f3, a, $urandom, 1'b0);
        n_total++;
        if (bus.o_done !== 1'b1 || bus.o_err !== 1'b1 || bus.o_rdata !== last_rdata ||
            bus.o_lsu_wren !== 1'b0 || bus.o_st_strb !== 4'd0)
            $display("FAIL mis_done f3=%0d a=%h: done=%b err=%b rdata=%h wren=%b strb=%b required 1 1 %h 0 0",
                     f3, a, bus.o_done, bus.o_err, bus.o_rdata, bus.o_lsu_wren, bus.o_st_strb, last_rdata);
        else n_pass++;
        @(posedge clk); #1;
        n_total++;
        if (bus.o_done !== 1'b0 || bus.o_err !== 1'b0 || bus.o_ready !== 1'b1)
            $display("FAIL mis_after a=%h: done=%b err=%b ready=%b required 0 0 1",
                     a, bus.o_done, bus.o_err, bus.o_ready);
        else n_pass++;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        #2;
        n_total++;
        if (bus.o_ready !== 1'b1 || bus.o_done !== 1'b0 || bus.o_err !== 1'b0 ||
            bus.o_rdata !== 32'd0 || bus.o_lsu_addr !== 32'd0 || bus.o_st_data !== 32'd0 ||
            bus.o_st_strb !== 4'd0 || bus.o_lsu_wren !== 1'b0)
            $display("FAIL reset: ready=%b done=%b err=%b rdata=%h addr=%h st=%h strb=%b wren=%b required 1 0 0 0 0 0 0 0",
                     bus.o_ready, bus.o_done, bus.o_err, bus.o_rdata, bus.o_lsu_addr,
                     bus.o_st_data, bus.o_st_strb, bus.o_lsu_wren);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_directed();
        run_store(3'b000, 32'h2003, 32'h0000_00AB);
        run_load(3'b001, 32'h2002, 32'h8001_1234, 1, 1'b0);
        run_load(3'b101, 32'h2002, 32'h8001_1234, 1, 1'b0);
        run_load(3'b100, 32'h2001, 32'h0000_C300, 1, 1'b0);
        run_load(3'b000, 32'h2001, 32'h0000_C300, 2, 1'b0);
        run_mis(1'b0, 3'b010, 32'h2006);
        run_mis(1'b1, 3'b001, 32'h2001);
        run_mis(1'b0, 3'b011, 32'h2000);
        run_store(3'b001, 32'h2002, 32'h1234_5678);
        run_store(3'b010, 32'h2004, 32'hCAFE_F00D);
        // valid held high from IDLE into LD_ADDR must not be captured
        run_load(3'b010, 32'h2004, 32'hDEAD_BEEF, 2, 1'b1);
        // answer on the last WAIT cycle the timeout allows
        run_load(3'b010, 32'h2008, 32'h0BAD_CAFE, 4, 1'b0);
    endtask

    task automatic test_back_to_back();
        int t;
        run_store(3'b010, 32'h3000, 32'h1111_2222);
        t = done_cyc;
        run_store(3'b000, 32'h3001, 32'h0000_0055);
        n_total++;
        if (done_cyc - t !== 3) $display("FAIL b2b_store: done spacing=%0d required 3", done_cyc - t);
        else n_pass++;
        t = done_cyc;
        run_load(3'b010, 32'h3000, 32'h3333_4444, 1, 1'b0);
        n_total++;
        if (done_cyc - t !== 4) $display("FAIL b2b_load: done spacing=%0d required 4", done_cyc - t);
        else n_pass++;
    endtask

    task automatic test_random();
        for (int i = 0; i < 60; i++) begin
            logic        wr = 1'($urandom);
            logic [2:0]  f3;
            logic [31:0] a = $urandom;
            int          sz;
            if ($urandom_range(0, 7) == 0) begin
                int r = $urandom_range(0, 2);
                f3 = (r == 0) ? 3'd3 : ((r == 1) ? 3'd6 : 3'd7);
            end else if (wr) begin
                f3 = 3'($urandom_range(0, 2));
            end else begin
                f3 = 3'($urandom_range(0, 4));
                if (f3 > 3'd2) f3 = f3 + 3'd1;
            end
            sz = m_size(f3);
            if (sz > 0 && $urandom_range(0, 3) != 0) a = a & ~32'(sz - 1);
            if (m_mis(f3, a))
                run_mis(wr, f3, a);
            else if (wr)
                run_store(f3, a, $urandom);
            else
                run_load(f3, a, $urandom, $urandom_range(1, 4), 1'($urandom));
        end
    endtask

    task automatic test_timeout();
`ifdef LSU_IF_TIMEOUT_EN
        issue(1'b0, 3'b010, 32'h4000, 32'd0, 1'b0);
        bus.i_data_vld = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            n_total++;
            if (c < 6) begin
                if (bus.o_done !== 1'b0)
                    $display("FAIL timeout_wait cycle %0d: done=%b required 0", c, bus.o_done);
                else n_pass++;
                @(posedge clk); #1;
            end else begin
                if (bus.o_done !== 1'b1 || bus.o_err !== 1'b1 || bus.o_rdata !== 32'd0)
                    $display("FAIL timeout_done: done=%b err=%b rdata=%h required 1 1 00000000",
                             bus.o_done, bus.o_err, bus.o_rdata);
                else n_pass++;
            end
        end
        last_rdata = 32'd0;
`endif
    endtask

    task automatic test_reset_mid();
        int seen = 0;
        run_load(3'b010, 32'h5000, 32'h5A5A_A5A5, 1, 1'b0);
        issue(1'b0, 3'b010, 32'h5004, 32'd0, 1'b0);
        bus.i_data_vld = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        n_total++;
        if (bus.o_ready !== 1'b1 || bus.o_done !== 1'b0 || bus.o_rdata !== 32'd0)
            $display("FAIL reset_mid: ready=%b done=%b rdata=%h required 1 0 00000000",
                     bus.o_ready, bus.o_done, bus.o_rdata);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            if (bus.o_done !== 1'b0) seen++;
        end
        n_total++;
        if (seen != 0) $display("FAIL reset_mid_nodone: done cycles=%0d required 0", seen);
        else n_pass++;
        last_rdata = 32'd0;
        run_load(3'b100, 32'h5003, 32'h9900_0000, 1, 1'b0);
    endtask

    initial begin
        bus.i_req = 1'b0; bus.i_wren = 1'b0; bus.i_funct3 = 3'd0;
        bus.i_addr = 32'd0; bus.i_wdata = 32'd0;
        bus.i_ld_data = 32'd0; bus.i_data_vld = 1'b0;
        test_reset();
        test_directed();
        test_back_to_back();
        test_random();
        test_timeout();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
`default_nettype wire
